// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM state encoding and response constants for the instruction-fetch responder.
package imem_pkg;
  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_WAIT = 2'd1,
    IMEM_RESP = 2'd2
  } imem_state_t;
  localparam logic [15:0] IMEM_ERR_DATA = 16'h0000;
  localparam int IMEM_WORD_BYTES = 2;
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x 16 instruction store, combinational read, synchronous write.
// Out-of-range write indices are dropped instead of aliasing onto low words.
module imem_array #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        i_we,
  input  logic [14:0] i_waddr,
  input  logic [15:0] i_wdata,
  input  logic [14:0] i_raddr,
  output logic [15:0] o_rdata,
  output logic        o_rin_range
);
  localparam int AW = $clog2(DEPTH);
  logic [15:0] r_mem [DEPTH];
  logic        w_win;
  assign w_win       = {1'b0, i_waddr} < 16'(DEPTH);
  assign o_rin_range = {1'b0, i_raddr} < 16'(DEPTH);
  assign o_rdata     = r_mem[i_raddr[AW-1:0]];
  always_ff @(posedge clk)
    if (i_we && w_win) r_mem[i_waddr[AW-1:0]] <= i_wdata;
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency valid/ready instruction-word responder with flush and loader port.
// Optional IMEM_PERF_CNT_EN adds acc_count / flush_count performance counters.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data
`ifdef IMEM_PERF_CNT_EN
  ,
  output logic [15:0] acc_count,
  output logic [7:0]  flush_count
`endif
);
  imem_state_t r_state, w_state_nx;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic [15:0] r_rsp_data, w_rdata;
  logic        r_rsp_err, w_in_range, w_err, w_accept, w_unused;
  imem_array #(.DEPTH(DEPTH)) u_array (
    .clk        (clk),
    .i_we       (ld_en),
    .i_waddr    (ld_addr[15:1]),
    .i_wdata    (ld_data),
    .i_raddr    (req_addr[15:1]),
    .o_rdata    (w_rdata),
    .o_rin_range(w_in_range)
  );
  assign w_unused  = ld_addr[0];
  assign req_ready = ~flush & (r_state == IMEM_IDLE | (r_state == IMEM_RESP & rsp_ready));
  assign w_accept  = req_valid & req_ready;
  assign w_err     = req_addr[0] | ~w_in_range;
  assign rsp_valid = r_state == IMEM_RESP;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (flush) w_state_nx = IMEM_IDLE;
    else if (w_accept) begin
      w_state_nx = (LATENCY == 1) ? IMEM_RESP : IMEM_WAIT;
      w_cnt_nx   = 4'(LATENCY - 1);
    end else if (r_state == IMEM_WAIT) begin
      w_cnt_nx   = r_cnt - 4'd1;
      w_state_nx = (r_cnt == 4'd1) ? IMEM_RESP : IMEM_WAIT;
    end else if (r_state == IMEM_RESP && rsp_ready) w_state_nx = IMEM_IDLE;
  end
  // Read data is captured in the accept cycle, so a same-cycle load returns the old word.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state    <= IMEM_IDLE;
      r_cnt      <= 4'd0;
      r_rsp_data <= 16'h0000;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_accept) begin
        r_rsp_data <= w_err ? IMEM_ERR_DATA : w_rdata;
        r_rsp_err  <= w_err;
      end
    end
`ifdef IMEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc_count   <= 16'h0000;
      flush_count <= 8'h00;
    end else begin
      if (w_accept) acc_count <= acc_count + 16'h0001;
      if (flush && r_state != IMEM_IDLE && flush_count != 8'hFF) flush_count <= flush_count + 8'h01;
    end
`endif
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed, table-driven bench for imem_responder (LATENCY=2 and LATENCY=1 instances).
// Checks acc_count / flush_count when IMEM_PERF_CNT_EN is defined.
module tb_imem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0, rsp_ready = 1'b0, flush = 1'b0, ld_en = 1'b0;
  logic [15:0] req_addr = 16'h0, ld_addr = 16'h0, ld_data = 16'h0;
  logic req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_data;
  logic req_valid1 = 1'b0, rsp_ready1 = 1'b0, flush1 = 1'b0;
  logic [15:0] req_addr1 = 16'h0;
  logic req_ready1, rsp_valid1, rsp_err1;
  logic [15:0] rsp_data1;
`ifdef IMEM_PERF_CNT_EN
  logic [15:0] acc_count, acc_count1;
  logic [7:0]  flush_count, flush_count1;
`endif
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH(256), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef IMEM_PERF_CNT_EN
    , .acc_count(acc_count), .flush_count(flush_count)
`endif
  );

  imem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_addr(req_addr1), .req_ready(req_ready1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_err(rsp_err1),
    .flush(flush1), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef IMEM_PERF_CNT_EN
    , .acc_count(acc_count1), .flush_count(flush_count1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Called at the first negedge after the accept edge; n counts edges from accept to rsp_valid.
  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_read(input string name, input logic [15:0] a, input logic [15:0] d, input logic e);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    #1 chk({name, " req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(n);
    chk({name, " latency"}, 32'(n), 32'd2);
    chk({name, " data"}, 32'(rsp_data), 32'(d));
    chk({name, " err"}, 32'(rsp_err), 32'(e));
    @(negedge clk);
    chk({name, " idle"}, 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [15:0] data;
    logic        err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n;
    vecs[0] = '{"rd w4",    16'h0008, 16'hA5C3, 1'b0};
    vecs[1] = '{"rd w5",    16'h000A, 16'hBEEF, 1'b0};
    vecs[2] = '{"rd w0",    16'h0000, 16'h1234, 1'b0};
    vecs[3] = '{"rd w255",  16'h01FE, 16'h7E57, 1'b0};
    vecs[4] = '{"misalign", 16'h0003, 16'h0000, 1'b1};
    vecs[5] = '{"oor 200",  16'h0200, 16'h0000, 1'b1};
    vecs[6] = '{"oor FFFE", 16'hFFFE, 16'h0000, 1'b1};
    vecs[7] = '{"odd 9",    16'h0009, 16'h0000, 1'b1};

    #12;
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_data", 32'(rsp_data), 32'd0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    load(16'h0008, 16'hA5C3);
    load(16'h000A, 16'hBEEF);
    load(16'h0000, 16'h1234);
    load(16'h01FE, 16'h7E57);
    load(16'h0200, 16'hDEAD);
    foreach (vecs[i]) do_read(vecs[i].name, vecs[i].addr, vecs[i].data, vecs[i].err);

    // backpressure then back-to-back handshake + accept
    @(negedge clk);
    req_valid = 1'b1; req_addr = 16'h0008; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(n);
    chk("bp latency", 32'(n), 32'd2);
    for (int k = 0; k < 3; k++) begin
      chk("bp valid held", 32'(rsp_valid), 32'd1);
      chk("bp data held", 32'(rsp_data), 32'hA5C3);
      chk("bp req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 16'h000A;
    #1 chk("b2b req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b wait", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("b2b valid", 32'(rsp_valid), 32'd1);
    chk("b2b data", 32'(rsp_data), 32'hBEEF);
    @(negedge clk);
    chk("b2b idle", 32'(rsp_valid), 32'd0);

    // flush in WAIT
    req_valid = 1'b1; req_addr = 16'h0008;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("flush wait no rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end

    // flush in RESP with rsp_ready and a competing request
    req_valid = 1'b1; req_addr = 16'h0008; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(n);
    chk("flush resp valid", 32'(rsp_valid), 32'd1);
    flush = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 16'h000A;
    #1 chk("flush req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    chk("flush resp idle", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("flush no accept", 32'(rsp_valid), 32'd0);
    do_read("post flush", 16'h000A, 16'hBEEF, 1'b0);

    // load/read hazard: same-cycle load returns old data
    @(negedge clk);
    req_valid = 1'b1; req_addr = 16'h0008; rsp_ready = 1'b1;
    ld_en = 1'b1; ld_addr = 16'h0008; ld_data = 16'h1111;
    @(negedge clk);
    req_valid = 1'b0; ld_en = 1'b0;
    wait_rsp(n);
    chk("hazard old data", 32'(rsp_data), 32'hA5C3);
    do_read("hazard new", 16'h0008, 16'h1111, 1'b0);

    // LATENCY=1 instance
    @(negedge clk);
    req_valid1 = 1'b1; req_addr1 = 16'h000A; rsp_ready1 = 1'b1;
    @(negedge clk);
    req_valid1 = 1'b0;
    chk("lat1 valid", 32'(rsp_valid1), 32'd1);
    chk("lat1 data", 32'(rsp_data1), 32'hBEEF);
    chk("lat1 err", 32'(rsp_err1), 32'd0);
    @(negedge clk);
    chk("lat1 idle", 32'(rsp_valid1), 32'd0);

    // async reset mid-WAIT
    req_valid = 1'b1; req_addr = 16'h0008;
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst valid", 32'(rsp_valid), 32'd0);
    chk("arst data", 32'(rsp_data), 32'd0);
    chk("arst err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("arst no rsp", 32'(rsp_valid), 32'd0);
    end

`ifdef IMEM_PERF_CNT_EN
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    do_read("perf rd", 16'h0008, 16'h1111, 1'b0);
    req_valid = 1'b1; req_addr = 16'h0008;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("acc_count", 32'(acc_count), 32'd2);
    chk("flush_count", 32'(flush_count), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
